// File: rtl/ip_ttl_header_stage.sv
// IPv4 header stage: decrements TTL, patches the header checksum, and tags each
// packet in TUSER (destination IP plus class flags) for the LPM/ARP lookup stage.
// TTL-expired packets are steered to the CPU port paired with the ingress port.
module ip_ttl_header_stage #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int SRC_PORT_POS         = 16,
   parameter int DST_PORT_POS         = 24,
   parameter int DIP_POS              = 32,
   parameter int FLAG_POS             = 64
) (
   input  logic                              AXI_ACLK,
   input  logic                              AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic                              S_AXIS_TLAST,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic                              M_AXIS_TLAST,
   output logic [31:0]                       ipv4_count,
   output logic [31:0]                       ttl_expired_count,
   output logic [31:0]                       non_ip_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT2 = 2'd1, BODY = 2'd2} state_t;

   state_t                             state_q, state_d;
   logic                               r_valid_q, r_valid_d;
   logic                               r_last_q, r_last_d;
   logic [C_S_AXIS_DATA_WIDTH-1:0]     r_data_q, r_data_d;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0]   r_strb_q, r_strb_d;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]    r_user_q, r_user_d;
   logic [31:0]                        ipv4_count_q, ipv4_count_d;
   logic [31:0]                        ttl_expired_count_q, ttl_expired_count_d;
   logic [31:0]                        non_ip_count_q, non_ip_count_d;

   logic                               is_ipv4;
   logic                               ttl_live;
   logic [7:0]                         ttl;
   logic [15:0]                        csum;
   logic [16:0]                        csum_sum;
   logic [15:0]                        csum_new;
   logic [C_S_AXIS_DATA_WIDTH-1:0]     beat1_data;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]    beat1_user;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]    single_user;
   logic                               m_valid;
   logic                               s_ready;
   logic                               m_fire;
   logic                               s_fire;
   logic                               load_beat;
   logic                               first_beat;

   // Decode the header fields of the first beat held in R and precompute the patched checksum.
   always_comb begin
      ttl      = r_data_q[79:72];
      csum     = r_data_q[63:48];
      is_ipv4  = (r_data_q[159:144] == 16'h0800) && (r_data_q[143:140] == 4'd4)
                 && (r_data_q[139:136] >= 4'd5);
      ttl_live = (ttl > 8'd1);
      csum_sum = {1'b0, csum} + 17'h00100;
      csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};
   end

   // Build the rewritten first beat; the low half of the dst IP comes from the live second beat.
   always_comb begin
      beat1_data                       = r_data_q;
      beat1_user                       = r_user_q;
      beat1_user[DIP_POS +: 32]        = {r_data_q[15:0], S_AXIS_TDATA[255:240]};
      if (is_ipv4 && ttl_live) begin
         beat1_data[79:72]             = ttl - 8'd1;
         beat1_data[63:48]             = csum_new;
         beat1_user[FLAG_POS +: 3]     = 3'b001;
      end else if (is_ipv4) begin
         beat1_user[DST_PORT_POS +: 8] = {r_user_q[SRC_PORT_POS +: 7], 1'b0};
         beat1_user[FLAG_POS +: 3]     = 3'b010;
      end else begin
         beat1_user[FLAG_POS +: 3]     = 3'b100;
      end
      single_user                      = S_AXIS_TUSER;
      single_user[DIP_POS +: 32]       = 32'd0;
      single_user[FLAG_POS +: 3]       = 3'b100;
   end

   // Drive the stream handshakes and egress beat; everything is held quiet while in reset.
   always_comb begin
      m_valid      = 1'b0;
      s_ready      = 1'b0;
      M_AXIS_TDATA = r_data_q;
      M_AXIS_TSTRB = r_strb_q;
      M_AXIS_TUSER = r_user_q;
      M_AXIS_TLAST = r_last_q;
      case (state_q)
         WAIT2: begin
            m_valid      = r_valid_q & S_AXIS_TVALID;
            s_ready      = M_AXIS_TREADY;
            M_AXIS_TDATA = beat1_data;
            M_AXIS_TUSER = beat1_user;
         end
         default: begin
            m_valid = r_valid_q;
            s_ready = !r_valid_q | M_AXIS_TREADY;
         end
      endcase
      if (AXI_RESET) begin
         m_valid      = 1'b0;
         s_ready      = 1'b0;
         M_AXIS_TDATA = '0;
         M_AXIS_TSTRB = '0;
         M_AXIS_TUSER = '0;
         M_AXIS_TLAST = 1'b0;
      end
      M_AXIS_TVALID = m_valid;
      S_AXIS_TREADY = s_ready;
   end

   assign m_fire = m_valid & M_AXIS_TREADY;
   assign s_fire = s_ready & S_AXIS_TVALID;

   // Next-state logic for the packet FSM, the R register and the class counters.
   always_comb begin
      state_d             = state_q;
      r_valid_d           = r_valid_q;
      r_last_d            = r_last_q;
      r_data_d            = r_data_q;
      r_strb_d            = r_strb_q;
      r_user_d            = r_user_q;
      ipv4_count_d        = ipv4_count_q;
      ttl_expired_count_d = ttl_expired_count_q;
      non_ip_count_d      = non_ip_count_q;
      load_beat           = 1'b0;
      first_beat          = 1'b0;
      if (m_fire) begin
         r_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (m_fire) begin
               non_ip_count_d = non_ip_count_q + 32'd1;
            end
            load_beat  = s_fire;
            first_beat = s_fire;
         end
         WAIT2: begin
            if (m_fire) begin
               load_beat = 1'b1;
               state_d   = BODY;
               if (is_ipv4 && ttl_live) begin
                  ipv4_count_d = ipv4_count_q + 32'd1;
               end else if (is_ipv4) begin
                  ttl_expired_count_d = ttl_expired_count_q + 32'd1;
               end else begin
                  non_ip_count_d = non_ip_count_q + 32'd1;
               end
            end
         end
         BODY: begin
            load_beat = s_fire;
            if (m_fire && r_last_q) begin
               state_d    = IDLE;
               first_beat = s_fire;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (load_beat) begin
         r_valid_d = 1'b1;
         r_last_d  = S_AXIS_TLAST;
         r_data_d  = S_AXIS_TDATA;
         r_strb_d  = S_AXIS_TSTRB;
         r_user_d  = S_AXIS_TUSER;
         if (first_beat) begin
            if (S_AXIS_TLAST) begin
               r_user_d = single_user;
               state_d  = IDLE;
            end else begin
               state_d  = WAIT2;
            end
         end
      end
   end

   // State, R register and counters; reset drops any partial packet.
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) begin
         state_q             <= IDLE;
         r_valid_q           <= 1'b0;
         r_last_q            <= 1'b0;
         r_data_q            <= '0;
         r_strb_q            <= '0;
         r_user_q            <= '0;
         ipv4_count_q        <= 32'd0;
         ttl_expired_count_q <= 32'd0;
         non_ip_count_q      <= 32'd0;
      end else begin
         state_q             <= state_d;
         r_valid_q           <= r_valid_d;
         r_last_q            <= r_last_d;
         r_data_q            <= r_data_d;
         r_strb_q            <= r_strb_d;
         r_user_q            <= r_user_d;
         ipv4_count_q        <= ipv4_count_d;
         ttl_expired_count_q <= ttl_expired_count_d;
         non_ip_count_q      <= non_ip_count_d;
      end
   end

   assign ipv4_count        = ipv4_count_q;
   assign ttl_expired_count = ttl_expired_count_q;
   assign non_ip_count      = non_ip_count_q;

endmodule

// File: tb/tb_ip_ttl_header_stage.sv
// Testbench for ip_ttl_header_stage: byte-level frame reference model, expected-beat
// queue checked on the egress side, directed and randomized packet streams.
module tb_ip_ttl_header_stage;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  strb;
      logic [127:0] user;
      logic         last;
   } beat_t;

   logic          clk;
   logic          rst;
   logic [255:0]  s_data;
   logic [31:0]   s_strb;
   logic [127:0]  s_user;
   logic          s_valid;
   logic          s_last;
   logic          m_ready;
   logic          S_AXIS_TREADY;
   logic [255:0]  M_AXIS_TDATA;
   logic [31:0]   M_AXIS_TSTRB;
   logic [127:0]  M_AXIS_TUSER;
   logic          M_AXIS_TVALID;
   logic          M_AXIS_TLAST;
   logic [31:0]   ipv4_count;
   logic [31:0]   ttl_expired_count;
   logic [31:0]   non_ip_count;

   int            checks;
   int            errors;
   int            ready_mode;
   bit            rand_gaps;
   bit            pat [5];
   int            pat_idx;
   bit            stalled_prev;
   beat_t         exp_q [$];
   logic [31:0]   exp_ipv4;
   logic [31:0]   exp_ttl;
   logic [31:0]   exp_nonip;
   logic [7:0]    frame [256];
   logic [7:0]    efr [256];

   ip_ttl_header_stage dut (
      .AXI_ACLK          (clk),
      .AXI_RESET         (rst),
      .S_AXIS_TDATA      (s_data),
      .S_AXIS_TSTRB      (s_strb),
      .S_AXIS_TUSER      (s_user),
      .S_AXIS_TVALID     (s_valid),
      .S_AXIS_TREADY     (S_AXIS_TREADY),
      .S_AXIS_TLAST      (s_last),
      .M_AXIS_TDATA      (M_AXIS_TDATA),
      .M_AXIS_TSTRB      (M_AXIS_TSTRB),
      .M_AXIS_TUSER      (M_AXIS_TUSER),
      .M_AXIS_TVALID     (M_AXIS_TVALID),
      .M_AXIS_TREADY     (m_ready),
      .M_AXIS_TLAST      (M_AXIS_TLAST),
      .ipv4_count        (ipv4_count),
      .ttl_expired_count (ttl_expired_count),
      .non_ip_count      (non_ip_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Give up loudly if the run ever stops making progress.
   initial begin
      #800000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Downstream ready generator: always ready, 1,0,1,1,0 pattern, or fully stalled.
   initial begin
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
      pat_idx = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
               m_ready = pat[pat_idx];
               pat_idx = (pat_idx + 1) % 5;
            end
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Egress monitor: every valid beat must match the head of the expected queue,
   // and a stalled beat must stay valid on the following cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (stalled_prev) begin
            checkOutput("tvalid_hold", {255'd0, M_AXIS_TVALID}, 256'd1);
         end
         if (M_AXIS_TVALID) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_beat", {255'd0, M_AXIS_TVALID}, 256'd0);
            end else begin
               checkOutput("m_tdata", M_AXIS_TDATA, exp_q[0].data);
               checkOutput("m_tuser", {128'd0, M_AXIS_TUSER}, {128'd0, exp_q[0].user});
               checkOutput("m_tstrb", {224'd0, M_AXIS_TSTRB}, {224'd0, exp_q[0].strb});
               checkOutput("m_tlast", {255'd0, M_AXIS_TLAST}, {255'd0, exp_q[0].last});
               if (m_ready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
         stalled_prev = M_AXIS_TVALID && !m_ready;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   // Present one beat (called just after a rising edge) and hold it until accepted.
   task automatic applyStimulus(input logic [255:0] d, input logic [31:0] st,
                                input logic [127:0] u, input logic l);
      bit accepted;
      int n;
      if (rand_gaps) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      s_data   = d;
      s_strb   = st;
      s_user   = u;
      s_last   = l;
      s_valid  = 1'b1;
      accepted = 1'b0;
      n        = 0;
      while (!accepted && n < 1000) begin
         @(negedge clk);
         accepted = S_AXIS_TREADY;
         @(posedge clk);
         #1;
         n++;
      end
      if (!accepted) begin
         checkOutput("s_accept_timeout", {255'd0, accepted}, 256'd1);
      end
   endtask

   // Build a frame, run it through the reference model, queue expected beats, then
   // drive the first nsend beats of it.
   task automatic sendPacket(input int nbeats, input logic [15:0] et, input logic [7:0] vihl,
                             input logic [7:0] ttl, input logic [15:0] csum, input logic [31:0] dip,
                             input logic [7:0] src, input int nsend);
      logic [127:0] ub [8];
      logic [31:0]  sb [8];
      logic [127:0] eu;
      logic [255:0] d;
      beat_t        eb;
      bit           ipv4;
      int           c;
      for (int i = 0; i < 256; i++) begin
         frame[i] = 8'($urandom);
      end
      frame[12] = et[15:8];   frame[13] = et[7:0];
      frame[14] = vihl;       frame[22] = ttl;
      frame[24] = csum[15:8]; frame[25] = csum[7:0];
      frame[30] = dip[31:24]; frame[31] = dip[23:16];
      frame[32] = dip[15:8];  frame[33] = dip[7:0];
      for (int b = 0; b < 8; b++) begin
         ub[b] = {$urandom, $urandom, $urandom, $urandom};
         sb[b] = (b == nbeats - 1) ? 32'($urandom) : 32'hFFFF_FFFF;
      end
      ub[0][16 +: 8] = src;
      for (int i = 0; i < 256; i++) begin
         efr[i] = frame[i];
      end
      eu   = ub[0];
      ipv4 = (nbeats >= 2) && ({frame[12], frame[13]} == 16'h0800)
             && (frame[14][7:4] == 4'd4) && (frame[14][3:0] >= 4'd5);
      eu[32 +: 32] = (nbeats >= 2) ? {frame[30], frame[31], frame[32], frame[33]} : 32'd0;
      if (ipv4 && frame[22] > 8'd1) begin
         efr[22] = frame[22] - 8'd1;
         c = int'({frame[24], frame[25]}) + 256;
         if (c > 65535) c = c - 65535;
         efr[24] = c[15:8];
         efr[25] = c[7:0];
         eu[64 +: 3] = 3'b001;
         exp_ipv4++;
      end else if (ipv4) begin
         eu[24 +: 8] = 8'(ub[0][16 +: 8] * 2);
         eu[64 +: 3] = 3'b010;
         exp_ttl++;
      end else begin
         eu[64 +: 3] = 3'b100;
         exp_nonip++;
      end
      for (int b = 0; b < nbeats; b++) begin
         for (int k = 0; k < 32; k++) begin
            eb.data[255-8*k -: 8] = efr[32*b+k];
         end
         eb.strb = sb[b];
         eb.user = (b == 0) ? eu : ub[b];
         eb.last = (b == nbeats - 1);
         exp_q.push_back(eb);
      end
      for (int b = 0; b < nsend; b++) begin
         for (int k = 0; k < 32; k++) begin
            d[255-8*k -: 8] = frame[32*b+k];
         end
         applyStimulus(d, sb[b], ub[b], (b == nbeats - 1));
      end
      s_valid = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput({tag, "_drain"}, 256'(exp_q.size()), 256'd0);
   endtask

   task automatic checkCounters(input string tag);
      @(negedge clk);
      checkOutput({tag, "_ipv4_count"}, {224'd0, ipv4_count}, {224'd0, exp_ipv4});
      checkOutput({tag, "_ttl_expired_count"}, {224'd0, ttl_expired_count}, {224'd0, exp_ttl});
      checkOutput({tag, "_non_ip_count"}, {224'd0, non_ip_count}, {224'd0, exp_nonip});
      @(posedge clk);
      #1;
   endtask

   // Directed and randomized test sequence.
   initial begin
      int kind;
      int nb;
      checks     = 0;
      errors     = 0;
      ready_mode = 0;
      rand_gaps  = 1'b0;
      exp_ipv4   = 32'd0;
      exp_ttl    = 32'd0;
      exp_nonip  = 32'd0;
      rst        = 1'b1;
      s_valid    = 1'b0;
      s_data     = '0;
      s_strb     = '0;
      s_user     = '0;
      s_last     = 1'b0;

      $display("[TB] reset state");
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_m_tvalid", {255'd0, M_AXIS_TVALID}, 256'd0);
      checkOutput("rst_s_tready", {255'd0, S_AXIS_TREADY}, 256'd0);
      checkOutput("rst_m_tdata", M_AXIS_TDATA, 256'd0);
      checkOutput("rst_m_tuser", {128'd0, M_AXIS_TUSER}, 256'd0);
      checkCounters("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] IPv4 TTL 0x40 forward");
      sendPacket(3, 16'h0800, 8'h45, 8'h40, 16'hB1E6, 32'h0A000102, 8'h01, 3);
      waitDrain("fwd");
      checkCounters("fwd");

      $display("[TB] IPv4 TTL 0x01 expired");
      sendPacket(3, 16'h0800, 8'h45, 8'h01, 16'h1234, 32'hC0A80001, 8'h04, 3);
      waitDrain("exp1");
      checkCounters("exp1");

      $display("[TB] IPv4 TTL 0x00 expired, src port bit 7");
      sendPacket(2, 16'h0800, 8'h46, 8'h00, 16'hABCD, 32'h01020304, 8'h80, 2);
      waitDrain("exp0");
      checkCounters("exp0");

      $display("[TB] checksum wrap");
      sendPacket(2, 16'h0800, 8'h45, 8'h0A, 16'hFF00, 32'h08080808, 8'h02, 2);
      waitDrain("wrap");
      checkCounters("wrap");

      $display("[TB] non-IP and malformed headers");
      sendPacket(2, 16'h0806, 8'h45, 8'h40, 16'h0000, 32'h0A000001, 8'h01, 2);
      sendPacket(1, 16'h0800, 8'h45, 8'h40, 16'h1111, 32'h0A000002, 8'h01, 1);
      sendPacket(3, 16'h0800, 8'h44, 8'h40, 16'h2222, 32'h0A000003, 8'h02, 3);
      sendPacket(2, 16'h0800, 8'h65, 8'h40, 16'h3333, 32'h0A000004, 8'h08, 2);
      waitDrain("nonip");
      checkCounters("nonip");

      $display("[TB] 20 back-to-back IPv4 packets with backpressure");
      ready_mode = 1;
      rand_gaps  = 1'b1;
      for (int p = 0; p < 20; p++) begin
         sendPacket(4, 16'h0800, 8'h45, 8'($urandom_range(2, 255)), 16'($urandom),
                    $urandom, 8'(1 << $urandom_range(0, 7)), 4);
      end
      waitDrain("b2b");
      checkCounters("b2b");

      $display("[TB] reset while R holds beat 2");
      ready_mode = 0;
      rand_gaps  = 1'b0;
      sendPacket(3, 16'h0800, 8'h45, 8'h40, 16'h4444, 32'h0A0A0A0A, 8'h01, 2);
      ready_mode = 2;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_rst_m_tvalid", {255'd0, M_AXIS_TVALID}, 256'd0);
      checkOutput("mid_rst_s_tready", {255'd0, S_AXIS_TREADY}, 256'd0);
      checkOutput("mid_rst_m_tdata", M_AXIS_TDATA, 256'd0);
      checkOutput("mid_rst_m_tuser", {128'd0, M_AXIS_TUSER}, 256'd0);
      checkOutput("mid_rst_m_tlast", {255'd0, M_AXIS_TLAST}, 256'd0);
      exp_q.delete();
      exp_ipv4  = 32'd0;
      exp_ttl   = 32'd0;
      exp_nonip = 32'd0;
      checkCounters("mid_rst");
      rst        = 1'b0;
      ready_mode = 0;
      @(posedge clk);
      #1;
      sendPacket(3, 16'h0800, 8'h45, 8'h20, 16'h5555, 32'h0B0C0D0E, 8'h02, 3);
      waitDrain("post_rst");
      checkCounters("post_rst");

      $display("[TB] random mix");
      ready_mode = 1;
      rand_gaps  = 1'b1;
      for (int p = 0; p < 16; p++) begin
         kind = $urandom_range(0, 2);
         nb   = $urandom_range(1, 5);
         case (kind)
            0: sendPacket(nb, 16'h0800, 8'h45, 8'($urandom), 16'($urandom), $urandom,
                          8'(1 << $urandom_range(0, 7)), nb);
            1: sendPacket(nb, 16'h86DD, 8'h60, 8'($urandom), 16'($urandom), $urandom,
                          8'(1 << $urandom_range(0, 7)), nb);
            default: sendPacket(nb, 16'h0800, 8'h43, 8'($urandom), 16'($urandom), $urandom,
                                8'(1 << $urandom_range(0, 7)), nb);
         endcase
      end
      waitDrain("mix");
      checkCounters("mix");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
